// File: rtl/eth_rmii_rx_pkg.sv
// Shared definitions for the RMII receive path: CRC-32 constants, line-code dibits,
// receive FSM encoding and a byte-wide reflected CRC-32 step.
package eth_rmii_rx_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT      = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } rx_state_t;

  // One byte through the LSB-first CRC-32 (no final inversion).
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide reflected CRC-32 register; Init has priority over En. Shared by RX and TX.
module eth_crc32
  import eth_rmii_rx_pkg::*;
(
  input  logic        clk,
  input  logic        Init,
  input  logic        En,
  input  logic [7:0]  Data,
  output logic [31:0] Crc
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (Init) begin
      crc_d = CRC32_INIT;
    end else if (En) begin
      crc_d = crc32_byte(crc_q, Data);
    end
  end

  always_ff @(posedge clk) begin
    crc_q <= crc_d;
  end

  assign Crc = crc_q;

endmodule

// File: rtl/eth_rmii_rx.sv
// RMII 100 Mb/s receive front end: preamble/SFD hunt, dibit-to-byte packing,
// length and FCS checking, framing strobes and saturating frame/error counters.
module eth_rmii_rx
  import eth_rmii_rx_pkg::*;
#(
  parameter int MIN_PRE_DIBITS = 8,
  parameter int MIN_BYTES      = 64,
  parameter int MAX_BYTES      = 1522
) (
  input  logic        Eth_Clk,
  input  logic        Eth_Rst,
  input  logic        Crs_Dv,
  input  logic [1:0]  Rxd,
  output logic [7:0]  Eth_Byte_Rx,
  output logic        Eth_Byte_Valid_Rx,
  output logic        Eth_Sof_Rx,
  output logic        Eth_Eof_Rx,
  output logic        Eth_Frame_Good_Rx,
  output logic        Eth_Frame_Bad_Rx,
  output logic [15:0] Rx_Frame_Cnt,
  output logic [15:0] Rx_Err_Cnt
);

  localparam logic [3:0]  MIN_PRE = 4'(MIN_PRE_DIBITS);
  localparam logic [10:0] MIN_LEN = 11'(MIN_BYTES);
  localparam logic [10:0] MAX_LEN = 11'(MAX_BYTES);

  logic       crs_q, crs_qq, smp_q;
  logic [1:0] rxd_q;

  rx_state_t   state_q, state_d;
  logic        boot_q, boot_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [5:0]  shreg_q, shreg_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic        drop_bad_q, drop_bad_d;
  logic [7:0]  byte_q, byte_d;
  logic        valid_q, valid_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic        good_q, good_d;
  logic        bad_q, bad_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic        carrier_end;
  logic        frame_ok;
  logic        crc_init, crc_en;
  logic [7:0]  crc_data;
  logic [31:0] crc_val;

  // smp_q marks that crs_q holds a real pin sample rather than its reset value.
  always_ff @(posedge Eth_Clk) begin
    if (Eth_Rst) begin
      crs_q  <= 1'b0;
      crs_qq <= 1'b0;
      rxd_q  <= 2'b00;
      smp_q  <= 1'b0;
    end else begin
      crs_q  <= Crs_Dv;
      crs_qq <= crs_q;
      rxd_q  <= Rxd;
      smp_q  <= 1'b1;
    end
  end

  eth_crc32 u_crc (
    .clk  (Eth_Clk),
    .Init (crc_init),
    .En   (crc_en),
    .Data (crc_data),
    .Crc  (crc_val)
  );

  // One low cycle is the RMII end-of-frame toggle and still carries data.
  assign carrier_end = !crs_q && !crs_qq;

  always_comb begin
    state_d     = state_q;
    boot_d      = boot_q;
    pre_cnt_d   = pre_cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    byte_cnt_d  = byte_cnt_q;
    drop_bad_d  = drop_bad_q;
    byte_d      = byte_q;
    valid_d     = 1'b0;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    good_d      = 1'b0;
    bad_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    crc_init    = Eth_Rst;
    crc_en      = 1'b0;
    crc_data    = {rxd_q, shreg_q};
    frame_ok    = (crc_val == CRC32_RESIDUE) && (byte_cnt_q >= MIN_LEN) &&
                  (byte_cnt_q <= MAX_LEN) && !idx_q[1];

    case (state_q)
      ST_IDLE: begin
        if (boot_q) begin
          // A carrier already up at the first real sample is a frame we joined late.
          if (smp_q) begin
            boot_d = 1'b0;
            if (crs_q) begin
              state_d    = ST_DROP;
              drop_bad_d = 1'b0;
            end
          end
        end else if (crs_q && rxd_q == PREAMBLE_DIBIT) begin
          state_d   = ST_PRE;
          pre_cnt_d = 4'd1;
        end
      end

      ST_PRE: begin
        if (carrier_end) begin
          state_d = ST_IDLE;
        end else if (rxd_q == PREAMBLE_DIBIT) begin
          if (pre_cnt_q != 4'hF) begin
            pre_cnt_d = pre_cnt_q + 4'd1;
          end
        end else if (rxd_q == SFD_DIBIT && pre_cnt_q >= MIN_PRE) begin
          state_d    = ST_DATA;
          idx_d      = 2'd0;
          byte_cnt_d = 11'd0;
          crc_init   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DATA: begin
        if (carrier_end) begin
          state_d = ST_IDLE;
          eof_d   = 1'b1;
          good_d  = frame_ok;
          bad_d   = !frame_ok;
        end else begin
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0: shreg_d[1:0] = rxd_q;
            2'd1: shreg_d[3:2] = rxd_q;
            2'd2: shreg_d[5:4] = rxd_q;
            default: begin
              if (byte_cnt_q >= MAX_LEN) begin
                state_d    = ST_DROP;
                drop_bad_d = 1'b1;
              end else begin
                byte_d  = {rxd_q, shreg_q};
                valid_d = 1'b1;
                sof_d   = (byte_cnt_q == 11'd0);
                crc_en  = 1'b1;
                if (byte_cnt_q != 11'h7FF) begin
                  byte_cnt_d = byte_cnt_q + 11'd1;
                end
              end
            end
          endcase
        end
      end

      default: begin
        if (carrier_end) begin
          state_d    = ST_IDLE;
          eof_d      = drop_bad_q;
          bad_d      = drop_bad_q;
          drop_bad_d = 1'b0;
        end
      end
    endcase

    if (good_d && frame_cnt_q != 16'hFFFF) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    if (bad_d && err_cnt_q != 16'hFFFF) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Eth_Clk) begin
    if (Eth_Rst) begin
      state_q     <= ST_IDLE;
      boot_q      <= 1'b1;
      pre_cnt_q   <= 4'd0;
      idx_q       <= 2'd0;
      shreg_q     <= 6'd0;
      byte_cnt_q  <= 11'd0;
      drop_bad_q  <= 1'b0;
      byte_q      <= 8'd0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
      frame_cnt_q <= 16'd0;
      err_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      boot_q      <= boot_d;
      pre_cnt_q   <= pre_cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      byte_cnt_q  <= byte_cnt_d;
      drop_bad_q  <= drop_bad_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign Eth_Byte_Rx       = byte_q;
  assign Eth_Byte_Valid_Rx = valid_q;
  assign Eth_Sof_Rx        = sof_q;
  assign Eth_Eof_Rx        = eof_q;
  assign Eth_Frame_Good_Rx = good_q;
  assign Eth_Frame_Bad_Rx  = bad_q;
  assign Rx_Frame_Cnt      = frame_cnt_q;
  assign Rx_Err_Cnt        = err_cnt_q;

endmodule

// File: tb/tb_eth_rmii_rx.sv
// Directed frame table for eth_rmii_rx plus a mid-frame reset sequence.
module tb_eth_rmii_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        crs = 1'b0;
  logic [1:0]  rxd = 2'b00;
  logic [7:0]  byte_rx;
  logic        valid_rx, sof_rx, eof_rx, good_rx, bad_rx;
  logic [15:0] frame_cnt, err_cnt;

  eth_rmii_rx dut (
    .Eth_Clk           (clk),
    .Eth_Rst           (rst),
    .Crs_Dv            (crs),
    .Rxd               (rxd),
    .Eth_Byte_Rx       (byte_rx),
    .Eth_Byte_Valid_Rx (valid_rx),
    .Eth_Sof_Rx        (sof_rx),
    .Eth_Eof_Rx        (eof_rx),
    .Eth_Frame_Good_Rx (good_rx),
    .Eth_Frame_Bad_Rx  (bad_rx),
    .Rx_Frame_Cnt      (frame_cnt),
    .Rx_Err_Cnt        (err_cnt)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int payload;
    int pre_len;
    bit fcs_bad;
    bit toggle;
    int extra;
    int exp_n;
    bit exp_good;
    bit exp_bad;
  } vec_t;

  vec_t vecs[11];

  int n_total = 0;
  int n_bad   = 0;
  int model_good = 0;
  int model_err  = 0;

  logic [7:0] frm[$];
  logic [7:0] got[$];
  int  sof_idx[$];
  int  eof_n = 0, eof_cyc = 0, first_cyc = -1, stray_n = 0;
  bit  eof_good = 0, eof_bad = 0;
  int  drv_last = 0, drv_b0 = 0;

  always @(negedge clk) begin
    if (valid_rx) begin
      if (got.size() == 0) first_cyc = cyc;
      if (sof_rx) sof_idx.push_back(got.size());
      got.push_back(byte_rx);
    end else if (sof_rx) begin
      stray_n++;
    end
    if (eof_rx) begin
      eof_n++;
      eof_cyc  = cyc;
      eof_good = good_rx;
      eof_bad  = bad_rx;
      if (good_rx == bad_rx) stray_n++;
    end else if (good_rx || bad_rx) begin
      stray_n++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic clear_capture();
    got.delete();
    sof_idx.delete();
    eof_n     = 0;
    first_cyc = -1;
    eof_good  = 0;
    eof_bad   = 0;
  endtask

  function automatic logic [31:0] crc_calc();
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (frm[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ frm[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  task automatic send_frame(input int payload, input int pre_len, input bit fcs_bad,
                            input bit toggle, input int extra, input int rst_at);
    logic [1:0]  dq[$];
    bit          cq[$];
    logic [31:0] fcs;
    logic [7:0]  b;
    int          n, rst_idx, b0_idx;
    frm.delete();
    for (int i = 0; i < payload; i++) frm.push_back(8'(i));
    fcs = ~crc_calc();
    if (fcs_bad) fcs[0] = ~fcs[0];
    for (int k = 0; k < 4; k++) frm.push_back(fcs[8*k +: 8]);
    for (int i = 0; i < pre_len; i++) begin
      dq.push_back(2'b01);
      cq.push_back(1'b1);
    end
    dq.push_back(2'b11);
    cq.push_back(1'b1);
    foreach (frm[i]) begin
      b = frm[i];
      for (int k = 0; k < 4; k++) begin
        dq.push_back(b[2*k +: 2]);
        cq.push_back(1'b1);
      end
    end
    for (int i = 0; i < extra; i++) begin
      dq.push_back(2'b10);
      cq.push_back(1'b1);
    end
    n = dq.size();
    if (toggle) begin
      for (int j = n - 8; j < n; j++) cq[j] = ((n - 1 - j) % 2 == 0);
    end
    b0_idx  = pre_len + 1 + 3;
    rst_idx = pre_len + 1 + 4 * rst_at;
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      crs = cq[j];
      rxd = dq[j];
      if (j == n - 1) drv_last = cyc;
      if (j == b0_idx) drv_b0 = cyc;
      if (rst_at >= 0 && j == rst_idx) rst = 1'b1;
      if (rst_at >= 0 && j == rst_idx + 2) begin
        rst = 1'b0;
        clear_capture();
        model_good = 0;
        model_err  = 0;
      end
    end
    for (int j = 0; j < 12; j++) begin
      @(posedge clk);
      #1;
      crs = 1'b0;
      rxd = 2'b00;
    end
  endtask

  task automatic check_frame(input int id, input int exp_n, input bit exp_good, input bit exp_bad);
    int mism;
    int sof_ok;
    mism = 0;
    for (int i = 0; i < got.size() && i < frm.size(); i++) begin
      if (got[i] != frm[i]) mism++;
    end
    if (exp_n == 0) sof_ok = (sof_idx.size() == 0);
    else sof_ok = (sof_idx.size() == 1 && sof_idx[0] == 0);
    $display("frame %0d: strobes=%0d eof=%0d good=%0d bad=%0d frames=%0d errs=%0d",
             id, got.size(), eof_n, eof_good, eof_bad, frame_cnt, err_cnt);
    chk($sformatf("f%0d strobes", id), got.size(), exp_n);
    chk($sformatf("f%0d data_mismatches", id), mism, 0);
    chk($sformatf("f%0d sof", id), sof_ok, 1);
    chk($sformatf("f%0d eof_count", id), eof_n, int'(exp_good | exp_bad));
    chk($sformatf("f%0d good", id), int'(eof_good), int'(exp_good));
    chk($sformatf("f%0d bad", id), int'(eof_bad), int'(exp_bad));
    if (exp_good | exp_bad) chk($sformatf("f%0d eof_latency", id), eof_cyc - drv_last, 4);
    if (exp_n > 0) chk($sformatf("f%0d byte_latency", id), first_cyc - drv_b0, 2);
    model_good += int'(exp_good);
    model_err  += int'(exp_bad);
    chk($sformatf("f%0d frame_cnt", id), int'(frame_cnt), model_good);
    chk($sformatf("f%0d err_cnt", id), int'(err_cnt), model_err);
    clear_capture();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           payload pre fcs_bad toggle extra exp_n good bad
    vecs[0]  = '{60,   15, 0, 0, 0, 64,   1, 0};
    vecs[1]  = '{60,   15, 1, 0, 0, 64,   0, 1};
    vecs[2]  = '{60,   15, 0, 1, 0, 64,   1, 0};
    vecs[3]  = '{1596, 15, 0, 0, 0, 1522, 0, 1};
    vecs[4]  = '{36,   15, 0, 0, 0, 40,   0, 1};
    vecs[5]  = '{60,   15, 0, 0, 1, 64,   0, 1};
    vecs[6]  = '{59,   15, 0, 0, 0, 63,   0, 1};
    vecs[7]  = '{1518, 15, 0, 0, 0, 1522, 1, 0};
    vecs[8]  = '{60,   8,  0, 0, 0, 64,   1, 0};
    vecs[9]  = '{60,   7,  0, 0, 0, 0,    0, 0};
    vecs[10] = '{100,  10, 0, 1, 0, 104,  1, 0};

    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("reset: byte=%0h valid=%0d sof=%0d eof=%0d good=%0d bad=%0d frames=%0d errs=%0d",
             byte_rx, valid_rx, sof_rx, eof_rx, good_rx, bad_rx, frame_cnt, err_cnt);
    chk("rst byte", int'(byte_rx), 0);
    chk("rst valid", int'(valid_rx), 0);
    chk("rst sof_eof", int'({sof_rx, eof_rx}), 0);
    chk("rst good_bad", int'({good_rx, bad_rx}), 0);
    chk("rst frame_cnt", int'(frame_cnt), 0);
    chk("rst err_cnt", int'(err_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    clear_capture();

    for (int v = 0; v < 11; v++) begin
      send_frame(vecs[v].payload, vecs[v].pre_len, vecs[v].fcs_bad, vecs[v].toggle,
                 vecs[v].extra, -1);
      check_frame(v, vecs[v].exp_n, vecs[v].exp_good, vecs[v].exp_bad);
    end

    // Reset at byte 20 with the carrier still up: the rest of the frame is ignored.
    send_frame(60, 15, 0, 0, 0, 20);
    check_frame(100, 0, 0, 0);
    send_frame(60, 15, 0, 0, 0, -1);
    check_frame(101, 64, 1, 0);

    chk("stray sof/good/bad", stray_n, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
